// File: rtl/sort_out_collector.sv
// Collects the sorter's per-lane parallel output into a FIFO and re-emits it as a
// one-element-per-cycle valid/ready stream. Optional order check: SORT_COLLECT_ORDER_CHK_EN.
module sort_out_collector #(
  parameter int SORT_FUC_MAX_NUM        = 1024,
  parameter int SORT_PERF_OUTPORT_NUM   = 4,
  parameter int SORT_COLLECT_FIFO_DEPTH = 16,
  parameter int SORT_COLLECT_CNT_W      = 16,
  localparam int SORT_FUC_DATA_W        = $clog2(SORT_FUC_MAX_NUM)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [SORT_PERF_OUTPORT_NUM-1:0]                 sort_vld_i,
  input  logic [SORT_PERF_OUTPORT_NUM*SORT_FUC_DATA_W-1:0] sort_data_i,
  input  logic                                             sort_done_vld_i,
  input  logic                                             order_mode_i,
  output logic                                             m_vld_o,
  input  logic                                             m_rdy_i,
  output logic [SORT_FUC_DATA_W-1:0]                       m_data_o,
  output logic                                             m_last_o,
  output logic                                             empty_frame_o,
  output logic [SORT_COLLECT_CNT_W-1:0]                    frame_len_o,
  output logic                                             overflow_err_o,
  output logic                                             order_err_o
);

  localparam int unsigned W     = SORT_FUC_DATA_W;
  localparam int unsigned P     = SORT_PERF_OUTPORT_NUM;
  localparam int unsigned DEPTH = SORT_COLLECT_FIFO_DEPTH;
  localparam int unsigned AW    = $clog2(SORT_COLLECT_FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CW    = SORT_COLLECT_CNT_W;
  localparam int unsigned CW1   = CW + 1;

  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d, len_q, len_d;
  logic             ovf_q, ovf_d, empty_q, empty_d;

  logic [PW-1:0]    occ, free, n_wr, slot, newest;
  logic [CW:0]      cnt_sum;
  logic [CW-1:0]    cnt_after;
  logic             head_tag, vld, pop;

  always_comb begin
    occ      = wr_q - rd_q;
    free     = PW'(DEPTH) - occ;
    head_tag = tag_q[rd_q[AW-1:0]];
    // Keep the newest untagged entry resident so a late done can still tag it.
    vld      = (occ >= PW'(2)) || ((occ != '0) && head_tag);
    pop      = vld && m_rdy_i;

    data_d = data_q;
    tag_d  = tag_q;
    ovf_d  = ovf_q;
    n_wr   = '0;
    slot   = '0;
    for (int unsigned k = 0; k < P; k++) begin
      if (sort_vld_i[k]) begin
        if (n_wr < free) begin
          slot                = wr_q + n_wr;
          data_d[slot[AW-1:0]] = sort_data_i[k*W +: W];
          tag_d[slot[AW-1:0]]  = 1'b0;
          n_wr                = n_wr + PW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    cnt_sum   = {1'b0, cnt_q} + CW1'(n_wr);
    cnt_after = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    newest    = wr_q + n_wr - PW'(1);

    cnt_d   = cnt_after;
    len_d   = len_q;
    empty_d = 1'b0;
    if (sort_done_vld_i) begin
      cnt_d = '0;
      if (cnt_after == '0) begin
        empty_d = 1'b1;
        len_d   = '0;
      end else begin
        tag_d[newest[AW-1:0]] = 1'b1;
        len_d                 = cnt_after;
      end
    end

    wr_d = wr_q + n_wr;
    rd_d = rd_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
      tag_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      empty_q <= empty_d;
    end
  end

  assign m_vld_o        = vld;
  assign m_data_o       = data_q[rd_q[AW-1:0]];
  assign m_last_o       = head_tag && vld;
  assign empty_frame_o  = empty_q;
  assign frame_len_o    = len_q;
  assign overflow_err_o = ovf_q;

`ifdef SORT_COLLECT_ORDER_CHK_EN
  logic [W-1:0] prev_q, prev_d;
  logic         have_q, have_d, oerr_q, oerr_d;

  always_comb begin
    prev_d = prev_q;
    have_d = have_q;
    oerr_d = oerr_q;
    if (pop) begin
      if (have_q && ((!order_mode_i && (m_data_o < prev_q)) ||
                     ( order_mode_i && (m_data_o > prev_q))))
        oerr_d = 1'b1;
      // History restarts after the frame's last element leaves.
      have_d = !head_tag;
      prev_d = m_data_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      have_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
      oerr_q <= oerr_d;
    end
  end

  assign order_err_o = oerr_q;
`else
  logic unused_order_mode;
  assign unused_order_mode = order_mode_i;
  assign order_err_o       = 1'b0;
`endif

endmodule
